// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings for the SRAM responder.
//   - HTRANS, HSIZE and HRESP codes
//   - lane_mask(): byte-lane enables for an access of a given size at addr[1:0]
package ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'd0,
        SIZE_HALF = 3'd1,
        SIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01
    } hresp_e;

    // Size mask shifted into place; sizes above a word give no lanes.
    function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [2:0] size);
        logic [3:0] m;
        case (size)
            SIZE_BYTE: m = 4'b0001;
            SIZE_HALF: m = 4'b0011;
            SIZE_WORD: m = 4'b1111;
            default:   m = 4'b0000;
        endcase
        return m << a;
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// ahb_sram_mem: word-organised SRAM with per-byte write enables and a
// synchronous, registered read port. Contents and read register are not reset.
// Ports:
//   HCLK         clock
//   we[3:0]      byte write enables for word widx
//   widx, wdata  write word index / data
//   re, ridx     read enable / word index (rdata updates on the next edge)
//   rdata        registered read data
module ahb_sram_mem #(
    parameter int unsigned WORDS = 64,
    parameter int          AW    = 6
) (
    input  logic          HCLK,
    input  logic [3:0]    we,
    input  logic [AW-1:0] widx,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] ridx,
    output logic [31:0]   rdata
);

    logic [3:0][7:0] mem [WORDS];

    // Read-before-write on a shared index: the top forwards the new bytes.
    always_ff @(posedge HCLK) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[widx][b] <= wdata[b*8 +: 8];
        end
        if (re) rdata <= mem[ridx];
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM responder (single and INCR transfers, beat by beat).
// Illegal or out-of-range accesses get a two-cycle ERROR response.
// Optional build macro: WAIT_STATE_EN -- inserts WAIT_CYCLES wait states per beat.
// Ports:
//   HCLK, HRESET          clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS   address phase (sampled when HREADY = 1)
//   HWRITE, HSIZE, HBURST transfer attributes (HBURST is ignored)
//   HWDATA                write data (data phase)
//   HRDATA, HRESP, HREADY data-phase response
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter logic [31:0] START_ADDR     = 32'h0,
    parameter int unsigned DEPTH_IN_BYTES = 32'h100,
    parameter int unsigned WAIT_CYCLES    = 2
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP,
    output logic        HREADY
);

    localparam int unsigned WORDS = DEPTH_IN_BYTES / 4;
    localparam int          AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    if (DEPTH_IN_BYTES == 0 || DEPTH_IN_BYTES % 4 != 0) begin : g_bad_depth
        $error("DEPTH_IN_BYTES must be a non-zero multiple of 4");
    end
    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
`ifdef WAIT_STATE_EN
        ST_WAIT,
`endif
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Data-phase bookkeeping captured at address-phase sampling.
    typedef struct packed {
        logic          write;
        logic [3:0]    lanes;
        logic [AW-1:0] idx;
    } dphase_t;

    state_e      state;
    logic        hready_q;
    logic [1:0]  hresp_q;
    dphase_t     dph;

`ifdef WAIT_STATE_EN
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
    logic [3:0] wcnt;
`endif

    // ---------------- decode ----------------
    logic [31:0]   off;
    logic          sample, in_range, aligned, legal;
    logic [3:0]    lanes;
    logic [AW-1:0] aidx;

    assign sample   = hready_q & HSEL & HTRANS[1];
    assign off      = HADDR - START_ADDR;
    assign in_range = (HADDR >= START_ADDR) && (off < DEPTH_IN_BYTES);
    assign lanes    = lane_mask(HADDR[1:0], HSIZE);
    assign aidx     = off[AW+1:2];

    always_comb begin
        aligned = 1'b0;
        case (HSIZE)
            SIZE_BYTE: aligned = 1'b1;
            SIZE_HALF: aligned = ~HADDR[0];
            SIZE_WORD: aligned = (HADDR[1:0] == 2'b00);
            default:   aligned = 1'b0;
        endcase
    end

    assign legal = in_range & aligned;

    // ---------------- memory ----------------
    // ACCESS always has HREADY = 1, so a pending write commits on this edge.
    logic        commit, re;
    logic [3:0]  we;
    logic [31:0] mem_rdata;

    assign commit = (state == ST_ACCESS) & dph.write & ~HRESET;
    assign we     = commit ? dph.lanes : 4'b0000;
    assign re     = sample & legal & ~HWRITE & ~HRESET;

    ahb_sram_mem #(.WORDS(WORDS), .AW(AW)) u_mem (
        .HCLK  (HCLK),
        .we    (we),
        .widx  (dph.idx),
        .wdata (HWDATA),
        .re    (re),
        .ridx  (aidx),
        .rdata (mem_rdata)
    );

    // ---------------- read-after-write forwarding ----------------
    // The memory returns the pre-write word when a read is sampled on the
    // edge that commits a write to the same index; patch those bytes in.
    logic [3:0]  fwd_mask;
    logic [31:0] fwd_data;
    logic [31:0] rdata_mix;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            fwd_mask <= 4'b0000;
        end else if (re) begin
            fwd_mask <= (commit && dph.idx == aidx) ? dph.lanes : 4'b0000;
            fwd_data <= HWDATA;
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_lane
        assign rdata_mix[b*8 +: 8] = fwd_mask[b] ? fwd_data[b*8 +: 8] : mem_rdata[b*8 +: 8];
    end

    assign HRDATA = (state == ST_ACCESS && !dph.write) ? rdata_mix : 32'h0;
    assign HRESP  = hresp_q;
    assign HREADY = hready_q;

    // ---------------- FSM ----------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= RESP_OKAY;
            dph      <= '0;
`ifdef WAIT_STATE_EN
            wcnt     <= 4'd0;
`endif
        end else begin
            case (state)
                // Every HREADY = 1 state ends its transfer and may accept a new one.
                ST_IDLE, ST_ACCESS, ST_ERR2: begin
                    hresp_q <= RESP_OKAY;
                    if (sample && !legal) begin
                        state     <= ST_ERR1;
                        hready_q  <= 1'b0;
                        hresp_q   <= RESP_ERROR;
                        dph.write <= 1'b0;
                    end else if (sample) begin
                        dph <= '{write: HWRITE, lanes: lanes, idx: aidx};
`ifdef WAIT_STATE_EN
                        if (WAIT_CYCLES != 0) begin
                            state    <= ST_WAIT;
                            hready_q <= 1'b0;
                            wcnt     <= WAIT_INIT;
                        end else begin
                            state    <= ST_ACCESS;
                            hready_q <= 1'b1;
                        end
`else
                        state    <= ST_ACCESS;
                        hready_q <= 1'b1;
`endif
                    end else begin
                        state     <= ST_IDLE;
                        hready_q  <= 1'b1;
                        dph.write <= 1'b0;
                    end
                end
`ifdef WAIT_STATE_EN
                ST_WAIT: begin
                    if (wcnt == 4'd0) begin
                        state    <= ST_ACCESS;
                        hready_q <= 1'b1;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
`endif
                ST_ERR1: begin
                    state    <= ST_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= RESP_ERROR;
                end
                default: begin
                    state    <= ST_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= RESP_OKAY;
                end
            endcase
        end
    end

    logic unused;
    assign unused = ^{HBURST, HTRANS[0]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;
    localparam logic [31:0] START = 32'h0;
    localparam int          DEPTH = 256;
    localparam int          WC    = 3;
`ifdef WAIT_STATE_EN
    localparam int EXP_WAITS = WC;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic        HCLK = 0, HRESET = 1, HSEL = 0, HWRITE = 0;
    logic [31:0] HADDR = 0, HWDATA = 0;
    logic [1:0]  HTRANS = 0;
    logic [2:0]  HSIZE = 0, HBURST = 0;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;
    logic        HREADY;

    ahb_sram_slave #(.START_ADDR(START), .DEPTH_IN_BYTES(DEPTH), .WAIT_CYCLES(WC)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HRESP(HRESP), .HREADY(HREADY)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  mm [DEPTH];     // byte-addressed reference memory
    int          checks = 0, errors = 0;
    logic [31:0] pend_wdata = 0; // HWDATA owed to the phase last sampled

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit legal_f(input logic [31:0] a, input logic [2:0] s);
        if (a < START || a >= START + DEPTH) return 0;
        if (s > 2) return 0;
        return (a % (32'd1 << s)) == 0;
    endfunction

    // Wait for the edge that samples the phase currently on the bus.
    task automatic advance();
        int n = 0;
        bit r;
        do begin
            @(negedge HCLK);
            r = HREADY;
            @(posedge HCLK);
            #1;
            n++;
        end while (!r && n < 60);
        if (!r) chk("hready_timeout", 32'(r), 32'd1);
    endtask

    task automatic issue(input logic [31:0] a, input bit w, input logic [2:0] s,
                         input logic [31:0] wd, input logic [1:0] tr = 2'b10, input bit sel = 1);
        exp_t e;
        int   base;
        HWDATA = pend_wdata;
        HADDR  = a; HWRITE = w; HSIZE = s; HTRANS = tr; HSEL = sel; HBURST = 3'b001;
        pend_wdata = w ? wd : $urandom;
        if (sel && tr[1]) begin
            e.err = !legal_f(a, s); e.rd = !w; e.addr = a; e.data = '0;
            if (!e.err) begin
                base = int'(a - START);
                if (w) begin
                    for (int b = 0; b < (1 << s); b++)
                        mm[base + b] = wd[8 * ((base + b) % 4) +: 8];
                end else begin
                    base = base & ~3;
                    e.data = {mm[base+3], mm[base+2], mm[base+1], mm[base]};
                end
            end
            sbq.push_back(e);
        end
        advance();
    endtask

    task automatic idle();
        issue(32'h0, 0, 3'd0, 32'h0, 2'b00, 1);
    endtask

    // Monitor: pairs each completed data phase with the head of the scoreboard.
    initial begin
        bit   pending = 0;
        int   waits = 0;
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                pending = 0; waits = 0;
            end else begin
                if (pending) begin
                    if (!HREADY) begin
                        waits++;
                        if (sbq.size() > 0 && sbq[0].err)
                            chk($sformatf("err1_resp@%h", sbq[0].addr), 32'(HRESP), 32'd1);
                    end else if (sbq.size() == 0) begin
                        chk("sb_underflow", 32'd0, 32'd1);
                        pending = 0; waits = 0;
                    end else begin
                        e = sbq.pop_front();
                        chk($sformatf("hresp@%h", e.addr), 32'(HRESP), e.err ? 32'd1 : 32'd0);
                        chk($sformatf("waits@%h", e.addr), 32'(waits), e.err ? 32'd1 : 32'(EXP_WAITS));
                        if (e.rd && !e.err) chk($sformatf("hrdata@%h", e.addr), HRDATA, e.data);
                        pending = 0; waits = 0;
                    end
                end
                if (HREADY) pending = HSEL && HTRANS[1];
            end
        end
    end

    initial begin
        logic [31:0] a, last_a;
        logic [2:0]  s;
        logic [1:0]  tr;

        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_hready", 32'(HREADY), 32'd1);
        chk("rst_hresp",  32'(HRESP),  32'd0);
        chk("rst_hrdata", HRDATA,      32'd0);
        HRESET = 0;

        // Give every word a known value.
        for (int i = 0; i < DEPTH / 4; i++) issue(START + 32'(i * 4), 1, 3'd2, $urandom);
        idle();

        // Word write/read, then byte and halfword merges.
        issue(32'h10, 1, 3'd2, 32'hDEADBEEF); idle();
        issue(32'h10, 0, 3'd2, 0);            idle();
        issue(32'h10, 1, 3'd2, 32'h11223344); idle();
        issue(32'h13, 1, 3'd0, 32'hA5000000); idle();
        issue(32'h10, 0, 3'd2, 0);            idle();
        issue(32'h14, 1, 3'd2, 32'h01020304); idle();
        issue(32'h16, 1, 3'd1, 32'h5A5A0000); idle();
        issue(32'h14, 0, 3'd2, 0);            idle();

        // Back-to-back write then read of the same word (forwarding).
        issue(32'h20, 1, 3'd2, 32'hCAFEF00D);
        issue(32'h20, 0, 3'd2, 0);
        issue(32'h21, 1, 3'd0, 32'h00007700);
        issue(32'h20, 0, 3'd2, 0);
        issue(32'h22, 1, 3'd1, 32'h99880000);
        issue(32'h20, 0, 3'd0, 0);
        idle();

        // Illegal accesses: out of range, misaligned, oversize; memory must not change.
        issue(START + DEPTH, 1, 3'd2, 32'h12345678);
        issue(32'h01, 1, 3'd1, 32'hFFFFFFFF);
        issue(32'h02, 1, 3'd2, 32'hFFFFFFFF);
        issue(32'h04, 1, 3'd3, 32'hFFFFFFFF);
        issue(32'h00, 0, 3'd2, 0);
        issue(32'h04, 0, 3'd2, 0);
        idle();

        // INCR8 word burst from 0x40, then read it back as a burst.
        for (int i = 0; i < 8; i++) issue(32'h40 + 32'(4 * i), 1, 3'd2, $urandom, i == 0 ? 2'b10 : 2'b11);
        for (int i = 0; i < 8; i++) issue(32'h40 + 32'(4 * i), 0, 3'd2, 0, i == 0 ? 2'b10 : 2'b11);
        idle();

        // Randomized traffic, biased toward legal aligned accesses and address reuse.
        last_a = 32'h0;
        for (int n = 0; n < 400; n++) begin
            s = ($urandom_range(0, 11) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            a = ($urandom_range(0, 2) == 0) ? last_a : 32'($urandom_range(0, DEPTH + 7));
            if (s <= 2 && $urandom_range(0, 4) != 0) a = a & ~((32'd1 << s) - 1);
            case ($urandom_range(0, 9))
                0:       tr = 2'b00;
                1:       tr = 2'b01;
                2, 3, 4: tr = 2'b11;
                default: tr = 2'b10;
            endcase
            issue(a, 1'($urandom_range(0, 1)), s, $urandom, tr, $urandom_range(0, 15) != 0);
            last_a = a;
        end
        idle();
        idle();

        // Reset in the data phase of a write to 0x30: the write must be dropped.
        HWDATA = pend_wdata;
        HADDR = 32'h30; HWRITE = 1; HSIZE = 3'd2; HTRANS = 2'b10; HSEL = 1;
        advance();
        HRESET = 1; HTRANS = 2'b00; HWDATA = 32'hBAD0BAD0;
        pend_wdata = 32'h0;
        @(posedge HCLK);
        #1;
        chk("rst_mid_hready", 32'(HREADY), 32'd1);
        chk("rst_mid_hresp",  32'(HRESP),  32'd0);
        HRESET = 0;
        issue(32'h30, 0, 3'd2, 0);
        idle();
        idle();

        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
